// File: rtl/tt_seq_divider.sv
// tt_seq_divider: sequential restoring divider, one quotient bit per clock.
// An 8-bit dividend over a 4-bit divisor gives an 8-bit quotient and a 4-bit
// remainder. Operands come in and results go out through valid/ready
// handshakes.
//
// The dividend shift register also collects the quotient. Each step moves the
// dividend MSB into the partial remainder and shifts the new quotient bit into
// the register's LSB. After DVD_W steps the register holds only quotient bits.
//
// The result registers (quotient/remainder/div_by_zero) are loaded only on
// entry to DONE. They keep their values through RUN and IDLE until the next
// result replaces them.
module tt_seq_divider #(
    parameter int DVD_W = 8,
    parameter int DVS_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [DVD_W-1:0] dividend,
    input  logic [DVS_W-1:0] divisor,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [DVD_W-1:0] quotient,
    output logic [DVS_W-1:0] remainder,
    output logic             div_by_zero,
    output logic             busy
);

    localparam int CNT_W = $clog2(DVD_W + 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [DVD_W-1:0]   sh_q, sh_d;
    logic [DVS_W-1:0]   dvs_q, dvs_d;
    logic [DVS_W:0]     pr_q, pr_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [DVD_W-1:0]   quo_q, quo_d;
    logic [DVS_W-1:0]   rem_q, rem_d;
    logic               dz_q, dz_d;

    logic [DVS_W:0]     pr_shift;
    logic [DVS_W:0]     pr_sub;
    logic [DVS_W:0]     pr_next;
    logic               q_bit;
    logic [DVD_W-1:0]   sh_next;

    // One restoring step: bring in the next dividend bit, then try to subtract
    always_comb begin
        pr_shift = {pr_q[DVS_W-1:0], sh_q[DVD_W-1]};
        pr_sub   = pr_shift - {1'b0, dvs_q};
        q_bit    = (pr_shift >= {1'b0, dvs_q});
        pr_next  = q_bit ? pr_sub : pr_shift;
        sh_next  = {sh_q[DVD_W-2:0], q_bit};
    end

    // Next-state, datapath updates and handshake outputs
    always_comb begin
        state_d   = state_q;
        sh_d      = sh_q;
        dvs_d     = dvs_q;
        pr_d      = pr_q;
        cnt_d     = cnt_q;
        quo_d     = quo_q;
        rem_d     = rem_q;
        dz_d      = dz_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    if (divisor != '0) begin
                        sh_d    = dividend;
                        dvs_d   = divisor;
                        pr_d    = '0;
                        cnt_d   = CNT_W'(DVD_W);
                        state_d = ST_RUN;
                    end else begin
                        // Divide by zero has no iterations. The result is
                        // ready right away.
                        quo_d   = '1;
                        rem_d   = dividend[DVS_W-1:0];
                        dz_d    = 1'b1;
                        state_d = ST_DONE;
                    end
                end
            end
            ST_RUN: begin
                busy  = 1'b1;
                sh_d  = sh_next;
                pr_d  = pr_next;
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    quo_d   = sh_next;
                    rem_d   = pr_next[DVS_W-1:0];
                    dz_d    = 1'b0;
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers, cleared asynchronously
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            sh_q    <= '0;
            dvs_q   <= '0;
            pr_q    <= '0;
            cnt_q   <= '0;
            quo_q   <= '0;
            rem_q   <= '0;
            dz_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            sh_q    <= sh_d;
            dvs_q   <= dvs_d;
            pr_q    <= pr_d;
            cnt_q   <= cnt_d;
            quo_q   <= quo_d;
            rem_q   <= rem_d;
            dz_q    <= dz_d;
        end
    end

    assign quotient    = quo_q;
    assign remainder   = rem_q;
    assign div_by_zero = dz_q;

endmodule

// File: tb/tb_tt_seq_divider.sv
// Bench for tt_seq_divider. A behavioural model tracks the phase
// (idle / iterating / result) and the arithmetic result of each accepted
// operation. It is compared with the DUT on every falling edge. Directed
// operations pin the model with literal expectations, then every
// dividend/divisor pair runs with random back-pressure.
module tb_tt_seq_divider;
    localparam int DVD_W = 8;
    localparam int DVS_W = 4;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [DVD_W-1:0] dividend = '0;
    logic [DVS_W-1:0] divisor = '0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [DVD_W-1:0] quotient;
    logic [DVS_W-1:0] remainder;
    logic             div_by_zero;
    logic             busy;

    int total = 0;
    int bad = 0;

    tt_seq_divider #(.DVD_W(DVD_W), .DVS_W(DVS_W)) dut (
        .clk(clk),
        .rst(rst),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .dividend(dividend),
        .divisor(divisor),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .quotient(quotient),
        .remainder(remainder),
        .div_by_zero(div_by_zero),
        .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model state: 0 idle, 1 iterating, 2 result presented
    int               m_phase = 0;
    int               m_left = 0;
    logic [DVD_W-1:0] m_a = '0;
    logic [DVS_W-1:0] m_b = '0;
    logic             m_known = 1'b1;
    logic [DVD_W-1:0] m_q = '0;
    logic [DVS_W-1:0] m_r = '0;
    logic             m_dz = 1'b0;

    function automatic void model_result();
        logic [DVD_W-1:0] a;
        a = m_a;
        if (m_b == 0) begin
            m_q  = '1;
            m_r  = a[DVS_W-1:0];
            m_dz = 1'b1;
        end else begin
            m_q  = DVD_W'(int'(m_a) / int'(m_b));
            m_r  = DVS_W'(int'(m_a) % int'(m_b));
            m_dz = 1'b0;
        end
        m_known = 1'b1;
    endfunction

    // Compare DUT to model, then advance the model to predict the next edge
    always @(negedge clk) begin
        if (rst) begin
            m_phase = 0;
            m_known = 1'b1;
            m_q     = '0;
            m_r     = '0;
            m_dz    = 1'b0;
        end
        chk("mon_in_ready", in_ready, m_phase == 0);
        chk("mon_busy", busy, m_phase == 1);
        chk("mon_out_valid", out_valid, m_phase == 2);
        if (m_known) begin
            chk("mon_quotient", quotient, m_q);
            chk("mon_remainder", remainder, m_r);
            chk("mon_div_by_zero", div_by_zero, m_dz);
        end
        if (!rst) begin
            if (m_phase == 0) begin
                if (in_valid) begin
                    m_a     = dividend;
                    m_b     = divisor;
                    m_known = 1'b0;
                    if (divisor == 0) begin
                        model_result();
                        m_phase = 2;
                    end else begin
                        m_phase = 1;
                        m_left  = DVD_W;
                    end
                end
            end else if (m_phase == 1) begin
                m_left--;
                if (m_left == 0) begin
                    model_result();
                    m_phase = 2;
                end
            end else begin
                if (out_ready) begin
                    if (m_b != 0) begin
                        chk("invariant", int'(quotient) * int'(m_b) + int'(remainder), int'(m_a));
                        chk("rem_lt_divisor", remainder < m_b, 1);
                    end
                    m_phase = 0;
                end
            end
        end
    end

    // Entered and left at 1 time unit after a rising edge
    task automatic do_op(input logic [DVD_W-1:0] a, input logic [DVS_W-1:0] b,
                         input int stall, input bit pulse, input bit lit,
                         input logic [DVD_W-1:0] eq, input logic [DVS_W-1:0] er,
                         input logic edz, input int elat);
        int n;
        int lat;
        n = 0;
        while (!in_ready && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (!in_ready) chk("idle_wait", in_ready, 1);
        in_valid = 1'b1;
        dividend = a;
        divisor  = b;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        dividend = DVD_W'($urandom);
        divisor  = DVS_W'($urandom);
        lat = 1;
        while (!out_valid && lat < 40) begin
            out_ready = 1'($urandom_range(0, 1));
            @(posedge clk);
            #1;
            lat++;
        end
        out_ready = 1'b0;
        chk("out_valid_seen", out_valid, 1);
        chk("latency", lat, elat);
        if (lit) begin
            chk("lit_quotient", quotient, eq);
            chk("lit_remainder", remainder, er);
            chk("lit_div_by_zero", div_by_zero, edz);
        end
        for (int i = 0; i < stall; i++) begin
            if (pulse && i == 5) begin
                in_valid = 1'b1;
                dividend = 8'd50;
                divisor  = 4'd5;
            end
            if (pulse && i == 6) in_valid = 1'b0;
            @(posedge clk);
            #1;
            if (pulse) begin
                chk("stall_in_ready", in_ready, 0);
                chk("stall_out_valid", out_valid, 1);
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk("hs_out_valid_drop", out_valid, 0);
        chk("hs_back_idle", in_ready, 1);
        if (lit) chk("held_quotient", quotient, eq);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, bad=%0d", bad);
        $fatal(1, "watchdog");
    end

    initial begin
        #12;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_quotient", quotient, 0);
        chk("rst_remainder", remainder, 0);
        chk("rst_div_by_zero", div_by_zero, 0);
        #10;
        rst = 1'b0;
        @(posedge clk);
        #1;

        do_op(8'd200, 4'd7, 0, 1'b0, 1'b1, 8'd28, 4'd4, 1'b0, DVD_W + 1);
        do_op(8'd255, 4'd1, 2, 1'b0, 1'b1, 8'd255, 4'd0, 1'b0, DVD_W + 1);
        do_op(8'd5, 4'd9, 0, 1'b0, 1'b1, 8'd0, 4'd5, 1'b0, DVD_W + 1);
        do_op(8'd0, 4'd3, 1, 1'b0, 1'b1, 8'd0, 4'd0, 1'b0, DVD_W + 1);
        do_op(8'd255, 4'd15, 0, 1'b0, 1'b1, 8'd17, 4'd0, 1'b0, DVD_W + 1);
        do_op(8'd100, 4'd0, 0, 1'b0, 1'b1, 8'd255, 4'd4, 1'b1, 1);
        do_op(8'd100, 4'd10, 0, 1'b0, 1'b1, 8'd10, 4'd0, 1'b0, DVD_W + 1);

        // Back-pressure with an ignored operand pulse while the result waits
        do_op(8'd200, 4'd7, 20, 1'b1, 1'b1, 8'd28, 4'd4, 1'b0, DVD_W + 1);
        do_op(8'd100, 4'd10, 0, 1'b0, 1'b1, 8'd10, 4'd0, 1'b0, DVD_W + 1);

        // Asynchronous reset four cycles into a run
        in_valid = 1'b1;
        dividend = 8'd200;
        divisor  = 4'd7;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        chk("arst_in_ready", in_ready, 1);
        chk("arst_busy", busy, 0);
        chk("arst_out_valid", out_valid, 0);
        chk("arst_quotient", quotient, 0);
        chk("arst_remainder", remainder, 0);
        chk("arst_div_by_zero", div_by_zero, 0);
        @(posedge clk);
        @(posedge clk);
        #7;
        rst = 1'b0;
        @(posedge clk);
        #1;
        for (int i = 0; i < 12; i++) begin
            chk("aborted_no_valid", out_valid, 0);
            @(posedge clk);
            #1;
        end
        do_op(8'd99, 4'd8, 0, 1'b0, 1'b1, 8'd12, 4'd3, 1'b0, DVD_W + 1);

        // Every dividend against every nonzero divisor
        for (int a = 0; a < 256; a++) begin
            for (int b = 1; b < 16; b++) begin
                do_op(DVD_W'(a), DVS_W'(b), int'($urandom_range(0, 2)), 1'b0, 1'b0,
                      '0, '0, 1'b0, DVD_W + 1);
            end
        end

        repeat (3) @(posedge clk);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
